i2c_master_ctrl: RTL and testbench
==================================

Name: i2c_master_ctrl

Overview:
- Single-byte I2C master transaction sequencer.
- Gates the SCL clock divider through `en_clk` and consumes its one-cycle `scl_posedge`/`scl_negedge` strobes.
- Generates START, 7-bit address + R/W, ACK sampling, one data byte (write or read), master NACK, and STOP.
- Sits between the host command interface and the open-drain SCL/SDA pad logic.

Parameters:
- ADDR_W, 7, slave address width.
- DATA_W, 8, data byte width (bit counter sized to cover DATA_W).

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- cmd_valid  input  1  host requests a transaction
- cmd_ready  output  1  high only in IDLE; command accepted on cmd_valid&&cmd_ready
- cmd_addr  input  ADDR_W  slave address
- cmd_rw  input  1  0=write, 1=read
- cmd_wdata  input  DATA_W  byte to write
- rdata  output  DATA_W  byte read, valid when done=1 and rw=1
- done  output  1  one-cycle pulse at transaction end
- ack_err  output  1  slave NACKed address or write data
- busy  output  1  state != IDLE
- en_clk  output  1  enable to SCL divider
- scl_posedge  input  1  divider strobe: SCL rising point
- scl_negedge  input  1  divider strobe: SCL falling point
- scl_o  output  1  SCL level (1 = released)
- sda_o  output  1  SDA drive value (always 0 when driven)
- sda_oe  output  1  SDA drive enable (0 = released/high)
- sda_i  input  1  SDA pad sample

Behaviour:
- Clock is `clk`. Reset is `rst_n`, asynchronous, active-low.
- Reset values: scl_o=1, sda_oe=0, sda_o=0, en_clk=0, done=0, ack_err=0, rdata=0, busy=0, state=IDLE. cmd_ready=1 out of reset.
- Reset mid-transaction: immediate return to these values; no STOP is generated.
- All outputs except cmd_ready and busy are registered.
- States: IDLE, START, ADDR, ACK_A, WR, ACK_D, RD, MNACK, STOP.
- IDLE:
  - On accept: latch {cmd_addr,cmd_rw}, cmd_wdata; clear ack_err; en_clk<=1; sda_oe<=1 (SDA falls while SCL high = START); go START.
- Strobes:
  - scl_posedge sets scl_o=1; scl_negedge clears scl_o=0, except where stated below.
  - Strobes arriving when en_clk=0 are ignored.
  - scl_posedge and scl_negedge in the same cycle is illegal; posedge wins.
- SDA timing: SDA changes exactly one clk after the scl_negedge cycle (1-clk hold). It never changes while scl_o=1, except at START and STOP.
- START: first scl_negedge -> scl_o=0, bit counter=7, go ADDR.
- ADDR:
  - Drive bit[cnt] of {addr,rw}, MSB first: sda_oe = ~bit.
  - cnt decrements on each scl_negedge; after bit 0's negedge go ACK_A.
- ACK_A:
  - sda_oe=0. Sample sda_i on scl_posedge.
  - At scl_negedge: if sample=1, ack_err<=1 and go STOP; else go WR (rw=0) or RD (rw=1), cnt=DATA_W-1.
- WR: same shifting as ADDR using wdata; then ACK_D.
- ACK_D: as ACK_A; NACK sets ack_err. Go STOP either way.
- RD:
  - sda_oe=0. On each scl_posedge, rdata <= {rdata[DATA_W-2:0], sda_i}.
  - After bit 0's negedge go MNACK.
- MNACK: sda_oe=0 (master NACK, single byte); at scl_negedge go STOP.
- STOP:
  - sda_oe=1 (one clk after entry); scl_posedge -> scl_o=1.
  - At the next scl_negedge: scl_o stays 1, sda_oe<=0 (SDA rises while SCL high = STOP), en_clk<=0, done<=1 for one clk, go IDLE.
- cmd_valid while busy: ignored, not queued.
- Per transaction: exactly 19 scl_posedge strobes consumed (8 addr, 1 ack, 8 data, 1 ack/nack, 1 stop). A NACK on the address consumes 10.

Test Plan:
- Write, addr=0x50, wdata=0xA5, sda_i ACKs:
  - SCL/SDA decode to START, 0xA0, ACK, 0xA5, ACK, STOP.
  - 19 SCL highs; done pulses once; ack_err=0; en_clk returns 0.
- Read, addr=0x50; slave drives 0x3C:
  - Header 0xA1; rdata=0x3C at done; SDA released during MNACK; ack_err=0.
- Address NACK (sda_i=1 at ACK_A):
  - No data phase; STOP follows; ack_err=1; done after 10 SCL highs.
- Write with data NACK:
  - ack_err=1 at done.
  - Next command clears ack_err on acceptance.
- cmd_valid held high through a transaction:
  - cmd_ready=0 while busy; exactly one transaction until done.
  - The next is accepted the cycle after IDLE is re-entered.
- Assert rst_n=0 mid-WR:
  - scl_o=1, sda_oe=0, en_clk=0, busy=0 with no clk edge.
  - After release, a fresh write completes normally.
- Protocol checker throughout all scenarios: SDA never toggles while SCL=1 except at START and STOP.

Source files
------------

// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master sequencer: START, address+R/W, ACK, one data byte, NACK/STOP.
// SCL timing comes from an external divider's strobes; SDA is updated one clk after each SCL fall.
module i2c_master_ctrl #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic              cmd_rw,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              done,
    output logic              ack_err,
    output logic              busy,
    output logic              en_clk,
    input  logic              scl_posedge,
    input  logic              scl_negedge,
    output logic              scl_o,
    output logic              sda_o,
    output logic              sda_oe,
    input  logic              sda_i
);

    localparam int HDR_W   = ADDR_W + 1;
    localparam int CNT_MAX = (HDR_W > DATA_W) ? HDR_W : DATA_W;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [3:0] {
        IDLE, START, ADDR, ACK_A, WR, ACK_D, RD, MNACK, STOP
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [HDR_W-1:0]   hdr_reg, hdr_next;
    logic [DATA_W-1:0]  wdata_reg, wdata_next;
    logic [DATA_W-1:0]  rdata_reg, rdata_next;
    logic               ack_smp_reg, ack_smp_next;
    logic               scl_reg, scl_next;
    logic               sda_oe_reg, sda_oe_next;
    logic               en_clk_reg, en_clk_next;
    logic               done_reg, done_next;
    logic               ack_err_reg, ack_err_next;
    logic               pos, neg;

    // Strobes only count while the divider is enabled; a coincident pair resolves to posedge.
    assign pos = en_clk_reg & scl_posedge;
    assign neg = en_clk_reg & scl_negedge & ~scl_posedge;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            hdr_reg     <= '0;
            wdata_reg   <= '0;
            rdata_reg   <= '0;
            ack_smp_reg <= 1'b0;
            scl_reg     <= 1'b1;
            sda_oe_reg  <= 1'b0;
            en_clk_reg  <= 1'b0;
            done_reg    <= 1'b0;
            ack_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            hdr_reg     <= hdr_next;
            wdata_reg   <= wdata_next;
            rdata_reg   <= rdata_next;
            ack_smp_reg <= ack_smp_next;
            scl_reg     <= scl_next;
            sda_oe_reg  <= sda_oe_next;
            en_clk_reg  <= en_clk_next;
            done_reg    <= done_next;
            ack_err_reg <= ack_err_next;
        end
    end

    // sda_oe_next is derived from the registered state, so SDA trails each state change by one clk.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        hdr_next     = hdr_reg;
        wdata_next   = wdata_reg;
        rdata_next   = rdata_reg;
        ack_smp_next = ack_smp_reg;
        scl_next     = scl_reg;
        sda_oe_next  = 1'b0;
        en_clk_next  = en_clk_reg;
        done_next    = 1'b0;
        ack_err_next = ack_err_reg;

        if (pos) begin
            scl_next = 1'b1;
        end else if (neg) begin
            scl_next = 1'b0;
        end

        case (state_reg)
            IDLE: begin
                if (cmd_valid) begin
                    hdr_next     = {cmd_addr, cmd_rw};
                    wdata_next   = cmd_wdata;
                    ack_err_next = 1'b0;
                    en_clk_next  = 1'b1;
                    sda_oe_next  = 1'b1;
                    state_next   = START;
                end
            end
            START: begin
                sda_oe_next = 1'b1;
                if (neg) begin
                    cnt_next   = CNT_W'(HDR_W - 1);
                    state_next = ADDR;
                end
            end
            ADDR: begin
                sda_oe_next = ~hdr_reg[cnt_reg];
                if (neg) begin
                    if (cnt_reg == '0) begin
                        state_next = ACK_A;
                    end else begin
                        cnt_next = cnt_reg - CNT_W'(1);
                    end
                end
            end
            ACK_A: begin
                if (pos) begin
                    ack_smp_next = sda_i;
                end
                if (neg) begin
                    if (ack_smp_reg) begin
                        ack_err_next = 1'b1;
                        state_next   = STOP;
                    end else begin
                        cnt_next   = CNT_W'(DATA_W - 1);
                        state_next = hdr_reg[0] ? RD : WR;
                    end
                end
            end
            WR: begin
                sda_oe_next = ~wdata_reg[cnt_reg];
                if (neg) begin
                    if (cnt_reg == '0) begin
                        state_next = ACK_D;
                    end else begin
                        cnt_next = cnt_reg - CNT_W'(1);
                    end
                end
            end
            ACK_D: begin
                if (pos) begin
                    ack_smp_next = sda_i;
                end
                if (neg) begin
                    if (ack_smp_reg) begin
                        ack_err_next = 1'b1;
                    end
                    state_next = STOP;
                end
            end
            RD: begin
                if (pos) begin
                    rdata_next = {rdata_reg[DATA_W-2:0], sda_i};
                end
                if (neg) begin
                    if (cnt_reg == '0) begin
                        state_next = MNACK;
                    end else begin
                        cnt_next = cnt_reg - CNT_W'(1);
                    end
                end
            end
            MNACK: begin
                if (neg) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                sda_oe_next = 1'b1;
                // The final fall strobe is swallowed: SCL stays high while SDA is released.
                if (neg) begin
                    scl_next    = 1'b1;
                    sda_oe_next = 1'b0;
                    en_clk_next = 1'b0;
                    done_next   = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign cmd_ready = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);
    assign rdata     = rdata_reg;
    assign done      = done_reg;
    assign ack_err   = ack_err_reg;
    assign en_clk    = en_clk_reg;
    assign scl_o     = scl_reg;
    assign sda_o     = 1'b0;
    assign sda_oe    = sda_oe_reg;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed bench for i2c_master_ctrl: strobe divider model, simple slave, and a bus monitor
// that decodes SCL-high bits and flags SDA edges during SCL high other than START/STOP.
module tb_i2c_master_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready, cmd_rw;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_wdata, rdata;
    logic       done, ack_err, busy, en_clk;
    logic       scl_posedge, scl_negedge;
    logic       scl_o, sda_o, sda_oe, sda_i;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    i2c_master_ctrl #(.ADDR_W(7), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_rw(cmd_rw), .cmd_wdata(cmd_wdata), .rdata(rdata), .done(done),
        .ack_err(ack_err), .busy(busy), .en_clk(en_clk),
        .scl_posedge(scl_posedge), .scl_negedge(scl_negedge),
        .scl_o(scl_o), .sda_o(sda_o), .sda_oe(sda_oe), .sda_i(sda_i)
    );

    // Divider model: 4 clks per SCL half period, falling strobe first after enable.
    logic [1:0] div_cnt;
    logic       div_phase;
    always @(posedge clk) begin
        scl_posedge <= 1'b0;
        scl_negedge <= 1'b0;
        if (!rst_n || !en_clk) begin
            div_cnt   <= 2'd0;
            div_phase <= 1'b0;
        end else begin
            div_cnt <= div_cnt + 2'd1;
            if (div_cnt == 2'd3) begin
                if (div_phase) scl_posedge <= 1'b1;
                else           scl_negedge <= 1'b1;
                div_phase <= ~div_phase;
            end
        end
    end

    // Slave model keyed on the number of SCL falls since START.
    logic       s_ack_addr, s_ack_data, s_rw;
    logic [7:0] s_rbyte;
    int         fcnt = 0;
    logic       slave_low;
    always_comb begin
        slave_low = 1'b0;
        if (busy && s_ack_addr) begin
            if (fcnt == 9) slave_low = 1'b1;
            if (s_rw && fcnt >= 10 && fcnt <= 17 && !s_rbyte[3'(17 - fcnt)]) slave_low = 1'b1;
            if (!s_rw && fcnt == 18 && s_ack_data) slave_low = 1'b1;
        end
    end
    assign sda_i = ~(sda_oe | slave_low);

    // Bus monitor.
    logic        scl_p = 1'b1, sda_p = 1'b1, busy_p = 1'b0, done_p = 1'b0, rst_p = 1'b0;
    logic [31:0] bitlog = '0;
    int rise_total = 0, start_total = 0, stop_total = 0, done_total = 0;
    int viol_total = 0, dbl_total = 0;
    always @(negedge clk) begin
        if (rst_n && rst_p) begin
            if (scl_p && scl_o && (sda_i != sda_p)) begin
                if (!sda_i && !busy_p && busy)  start_total <= start_total + 1;
                else if (sda_i && done)         stop_total  <= stop_total + 1;
                else                            viol_total  <= viol_total + 1;
            end
            if (!scl_p && scl_o) begin
                rise_total <= rise_total + 1;
                bitlog     <= {bitlog[30:0], sda_i};
            end
            if (done) begin
                done_total <= done_total + 1;
                if (done_p) dbl_total <= dbl_total + 1;
            end
            if (!busy)                fcnt <= 0;
            else if (scl_p && !scl_o) fcnt <= fcnt + 1;
        end else begin
            fcnt <= 0;
        end
        scl_p  <= scl_o;
        sda_p  <= sda_i;
        busy_p <= busy;
        done_p <= done;
        rst_p  <= rst_n;
    end

    int b_rise, b_start, b_stop, b_done, b_viol, b_dbl;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_rise = rise_total; b_start = start_total; b_stop = stop_total;
        b_done = done_total; b_viol = viol_total;   b_dbl  = dbl_total;
    endtask

    task automatic cfg(input logic aa, input logic ad, input logic rw, input logic [7:0] rb);
        s_ack_addr = aa; s_ack_data = ad; s_rw = rw; s_rbyte = rb;
    endtask

    task automatic issue(input string tag, input logic [6:0] a, input logic rw,
                         input logic [7:0] wd, input logic hold);
        @(negedge clk);
        cmd_addr = a; cmd_rw = rw; cmd_wdata = wd; cmd_valid = 1'b1;
        @(negedge clk);
        if (!hold) cmd_valid = 1'b0;
        check({tag, "_accept_busy"}, 32'(busy), 32'h1);
        check({tag, "_accept_ack_err_clear"}, 32'(ack_err), 32'h0);
    endtask

    task automatic wait_done(input string tag, output logic a_err, output logic [7:0] rd,
                             output logic enc);
        logic seen;
        seen = 1'b0; a_err = 1'b0; rd = '0; enc = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                seen = 1'b1; a_err = ack_err; rd = rdata; enc = en_clk;
                break;
            end
        end
        check({tag, "_done_seen"}, 32'(seen), 32'h1);
    endtask

    task automatic post(input string tag, input int exp_rise, input int exp_n);
        repeat (3) @(negedge clk);
        check({tag, "_scl_highs"}, 32'(rise_total - b_rise), 32'(exp_rise));
        check({tag, "_done_pulses"}, 32'(done_total - b_done), 32'(exp_n));
        check({tag, "_starts"}, 32'(start_total - b_start), 32'(exp_n));
        check({tag, "_stops"}, 32'(stop_total - b_stop), 32'(exp_n));
        check({tag, "_sda_during_scl_high"}, 32'(viol_total - b_viol), 32'h0);
        check({tag, "_done_width"}, 32'(dbl_total - b_dbl), 32'h0);
    endtask

    logic       r_err, r_en;
    logic [7:0] r_data;
    logic       got;

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_rw = 1'b0; cmd_wdata = '0;
        cfg(1'b1, 1'b1, 1'b0, 8'h00);
        repeat (3) @(negedge clk);
        check("rst_scl_o", 32'(scl_o), 32'h1);
        check("rst_sda_oe", 32'(sda_oe), 32'h0);
        check("rst_sda_o", 32'(sda_o), 32'h0);
        check("rst_en_clk", 32'(en_clk), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_ack_err", 32'(ack_err), 32'h0);
        check("rst_rdata", 32'(rdata), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'h1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: write 0x50 <- 0xA5, both ACKed
        $display("txn write addr=50 data=A5 ack");
        cfg(1'b1, 1'b1, 1'b0, 8'h00); snap();
        issue("wr", 7'h50, 1'b0, 8'hA5, 1'b0);
        wait_done("wr", r_err, r_data, r_en);
        check("wr_ack_err", 32'(r_err), 32'h0);
        check("wr_en_clk_off", 32'(r_en), 32'h0);
        post("wr", 19, 1);
        check("wr_header", 32'(bitlog[18:11]), 32'hA0);
        check("wr_addr_ack", 32'(bitlog[10]), 32'h0);
        check("wr_data", 32'(bitlog[9:2]), 32'hA5);
        check("wr_data_ack", 32'(bitlog[1]), 32'h0);

        // 2: read 0x50, slave returns 0x3C
        $display("txn read addr=50 slave=3C");
        cfg(1'b1, 1'b1, 1'b1, 8'h3C); snap();
        issue("rd", 7'h50, 1'b1, 8'h00, 1'b0);
        wait_done("rd", r_err, r_data, r_en);
        check("rd_rdata", 32'(r_data), 32'h3C);
        check("rd_ack_err", 32'(r_err), 32'h0);
        post("rd", 19, 1);
        check("rd_header", 32'(bitlog[18:11]), 32'hA1);
        check("rd_bus_data", 32'(bitlog[9:2]), 32'h3C);
        check("rd_mnack_released", 32'(bitlog[1]), 32'h1);

        // 3: address NACK
        $display("txn write addr=50 address nack");
        cfg(1'b0, 1'b0, 1'b0, 8'h00); snap();
        issue("anack", 7'h50, 1'b0, 8'h11, 1'b0);
        wait_done("anack", r_err, r_data, r_en);
        check("anack_ack_err", 32'(r_err), 32'h1);
        post("anack", 10, 1);
        check("anack_header", 32'(bitlog[9:2]), 32'hA0);
        check("anack_ack_bit", 32'(bitlog[1]), 32'h1);

        // 4: data NACK, then a clean write clears ack_err on acceptance
        $display("txn write addr=50 data=C3 data nack");
        cfg(1'b1, 1'b0, 1'b0, 8'h00); snap();
        issue("dnack", 7'h50, 1'b0, 8'hC3, 1'b0);
        wait_done("dnack", r_err, r_data, r_en);
        check("dnack_ack_err", 32'(r_err), 32'h1);
        post("dnack", 19, 1);
        check("dnack_data", 32'(bitlog[9:2]), 32'hC3);
        check("dnack_ack_bit", 32'(bitlog[1]), 32'h1);
        $display("txn write addr=2A data=5A ack after nack");
        cfg(1'b1, 1'b1, 1'b0, 8'h00); snap();
        issue("clr", 7'h2A, 1'b0, 8'h5A, 1'b0);
        wait_done("clr", r_err, r_data, r_en);
        check("clr_ack_err", 32'(r_err), 32'h0);
        post("clr", 19, 1);
        check("clr_header", 32'(bitlog[18:11]), 32'h54);
        check("clr_data", 32'(bitlog[9:2]), 32'h5A);

        // 5: cmd_valid held high across a whole transaction
        $display("txn write addr=50 data=3C cmd_valid held");
        cfg(1'b1, 1'b1, 1'b0, 8'h00); snap();
        issue("hold", 7'h50, 1'b0, 8'h3C, 1'b1);
        repeat (20) @(negedge clk);
        check("hold_cmd_ready_busy", 32'(cmd_ready), 32'h0);
        wait_done("hold", r_err, r_data, r_en);
        check("hold_idle_at_done", 32'(busy), 32'h0);
        check("hold_ready_at_done", 32'(cmd_ready), 32'h1);
        check("hold_single_start", 32'(start_total - b_start), 32'h1);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("hold_reaccept_busy", 32'(busy), 32'h1);
        check("hold_reaccept_done_low", 32'(done), 32'h0);
        wait_done("hold2", r_err, r_data, r_en);
        post("hold", 38, 2);

        // 6: reset in the middle of the write data byte
        $display("txn write addr=50 data=00 reset mid-data");
        cfg(1'b1, 1'b1, 1'b0, 8'h00); snap();
        issue("rst", 7'h50, 1'b0, 8'h00, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if ((rise_total - b_rise) >= 12 && scl_o == 1'b0) begin
                got = 1'b1;
                break;
            end
        end
        check("rst_reached_wr", 32'(got), 32'h1);
        check("rst_pre_scl_low", 32'(scl_o), 32'h0);
        check("rst_pre_sda_driven", 32'(sda_oe), 32'h1);
        check("rst_pre_en_clk", 32'(en_clk), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check("rst_async_scl_o", 32'(scl_o), 32'h1);
        check("rst_async_sda_oe", 32'(sda_oe), 32'h0);
        check("rst_async_en_clk", 32'(en_clk), 32'h0);
        check("rst_async_busy", 32'(busy), 32'h0);
        repeat (2) @(negedge clk);
        check("rst_no_done", 32'(done), 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        $display("txn write addr=50 data=A5 after reset");
        snap();
        issue("post_rst", 7'h50, 1'b0, 8'hA5, 1'b0);
        wait_done("post_rst", r_err, r_data, r_en);
        check("post_rst_ack_err", 32'(r_err), 32'h0);
        post("post_rst", 19, 1);
        check("post_rst_header", 32'(bitlog[18:11]), 32'hA0);
        check("post_rst_data", 32'(bitlog[9:2]), 32'hA5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
